dag2_log_packer: RTL and testbench

- Downstream consumer of the 2-bit DAG logic result stream (`(a|b) & ((a|b)^b)`).
- Packs successive BITS-wide results into WORDS-lane words and buffers them in a DEPTH-entry FIFO.
- Presents packed words on a valid/ready interface to the next stage.
- Supports an explicit flush that emits a partially filled word.

---
 rtl/dag2_log_packer.sv | 207 ++++++++++++++++++++
 tb/tb_dag2_log_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dag2_log_packer.sv
// Packs BITS-wide logic results into WORDS-lane words behind a DEPTH-entry FIFO; a full or flushed
// word is visible one edge after completion, and in_ready depends only on registered state.

module dag2_log_packer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push_vld,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop_vld,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop_vld && (count_q != '0);
        // A push into a full FIFO is only legal when the head leaves in the same cycle.
        do_push  = push_vld && ((count_q < DEPTH_C) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module dag2_log_packer #(
    parameter int BITS  = 2,
    parameter int WORDS = 4,
    parameter int DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS*WORDS-1:0] out_data,
    output logic [2:0]            out_lanes,
    output logic [7:0]            packed_count
);
    localparam int ACC_W = BITS * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [2:0]       LANES_FULL = 3'(WORDS);

    localparam logic [0:0] ST_FILL       = 1'b0;
    localparam logic [0:0] ST_FLUSH_PEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       packed_count_q, packed_count_d;

    logic             accept;
    logic             pop;
    logic [ACC_W-1:0] acc_with;
    logic [2:0]       fill_lanes;
    logic             push_vld;
    logic [ACC_W-1:0] push_acc;
    logic [2:0]       push_lanes;
    logic [ACC_W+2:0] head_dat;
    logic [CNT_W-1:0] fifo_count;

    assign in_ready  = reset_n && (state_q == ST_FILL)
                       && ((idx_q != IDX_LAST) || (fifo_count < DEPTH_C));
    assign accept    = in_valid && in_ready;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    // Accumulator as it would look with this cycle's accepted result merged into lane idx.
    assign acc_with   = accept ? (acc_q | ({{(ACC_W-BITS){1'b0}}, in_data} << (idx_q * BITS)))
                               : acc_q;
    assign fill_lanes = 3'(idx_q) + 3'(accept);

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        packed_count_d = packed_count_q;
        push_vld       = 1'b0;
        push_acc       = '0;
        push_lanes     = '0;
        case (state_q)
            ST_FILL: begin
                if (accept && (idx_q == IDX_LAST)) begin
                    push_vld   = 1'b1;
                    push_acc   = acc_with;
                    push_lanes = LANES_FULL;
                    acc_d      = '0;
                    idx_d      = '0;
                end else if (flush && ((idx_q != '0) || accept)) begin
                    if ((fifo_count < DEPTH_C) || pop) begin
                        push_vld   = 1'b1;
                        push_acc   = acc_with;
                        push_lanes = fill_lanes;
                        acc_d      = '0;
                        idx_d      = '0;
                    end else begin
                        state_d = ST_FLUSH_PEND;
                        acc_d   = acc_with;
                        idx_d   = idx_q + IDX_W'(accept);
                    end
                end else if (accept) begin
                    acc_d = acc_with;
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_FLUSH_PEND: begin
                // Waits on the registered count only, so a pop frees the slot one edge later.
                if (fifo_count < DEPTH_C) begin
                    push_vld   = 1'b1;
                    push_acc   = acc_q;
                    push_lanes = 3'(idx_q);
                    acc_d      = '0;
                    idx_d      = '0;
                    state_d    = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
        if (push_vld) begin
            packed_count_d = packed_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_FILL;
            acc_q          <= '0;
            idx_q          <= '0;
            packed_count_q <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            packed_count_q <= packed_count_d;
        end
    end

    dag2_log_packer_fifo #(
        .WIDTH (ACC_W + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_vld (push_vld),
        .push_dat ({push_lanes, push_acc}),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    assign out_data     = out_valid ? head_dat[ACC_W-1:0]       : '0;
    assign out_lanes    = out_valid ? head_dat[ACC_W+2:ACC_W]   : '0;
    assign packed_count = packed_count_q;
endmodule

// File: tb/tb_dag2_log_packer.sv
// Directed bench for dag2_log_packer: packing, backpressure, flush, reset and count wrap.
module tb_dag2_log_packer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_data;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_lanes;
    logic [7:0] packed_count;

    int n_vec = 0;
    int n_bad = 0;

    dag2_log_packer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_lanes    (out_lanes),
        .packed_count (packed_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk("feed_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    logic [1:0] stream [12];
    int         acc;
    logic       rdy;

    initial begin
        stream   = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2};
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        chk("rst_lanes", 32'(out_lanes), 32'd0);
        chk("rst_count", 32'(packed_count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);

        // Basic full word 1,2,3,0 -> 0x39, visible for exactly one cycle.
        reset_n   = 1'b1;
        out_ready = 1'b1;
        feed(2'd1); feed(2'd2); feed(2'd3); feed(2'd0);
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_data",  32'(out_data), 32'h39);
        chk("w1_lanes", 32'(out_lanes), 32'd4);
        chk("w1_count", 32'(packed_count), 32'd1);
        tick();
        chk("w1_gone", 32'(out_valid), 32'd0);

        // Backpressure: 12 offered, 11 taken while the FIFO is held full.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_data  = stream[(acc < 12) ? acc : 11];
            #1;
            rdy = in_ready;
            tick();
            if (rdy) acc++;
        end
        chk("bp_accepts", 32'(acc), 32'd11);
        chk("bp_ready",   32'(in_ready), 32'd0);
        chk("bp_valid",   32'(out_valid), 32'd1);
        chk("bp_head",    32'(out_data), 32'h9C);
        chk("bp_count",   32'(packed_count), 32'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_nocomb", 32'(in_ready), 32'd0);
        tick();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_head2",      32'(out_data), 32'hDA);
        tick();
        in_valid = 1'b0;
        chk("bp_head3",  32'(out_data), 32'h93);
        chk("bp_lanes3", 32'(out_lanes), 32'd4);
        chk("bp_count3", 32'(packed_count), 32'd4);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush of a 2-lane partial word, then an ignored flush, then lane 0 restart.
        feed(2'd3); feed(2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd1);
        chk("fl_data",  32'(out_data), 32'h07);
        chk("fl_lanes", 32'(out_lanes), 32'd2);
        chk("fl_count", 32'(packed_count), 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty_valid", 32'(out_valid), 32'd0);
        chk("fl_empty_count", 32'(packed_count), 32'd5);
        feed(2'd2); feed(2'd0); feed(2'd0); feed(2'd0);
        chk("fl_lane0_data",  32'(out_data), 32'h02);
        chk("fl_lane0_lanes", 32'(out_lanes), 32'd4);
        chk("fl_lane0_count", 32'(packed_count), 32'd6);
        tick();
        feed(2'd1);
        in_valid = 1'b1;
        in_data  = 2'd3;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("fl_same_data",  32'(out_data), 32'h0D);
        chk("fl_same_lanes", 32'(out_lanes), 32'd2);
        chk("fl_same_count", 32'(packed_count), 32'd7);
        tick();
        chk("fl_same_gone", 32'(out_valid), 32'd0);

        // Flush against a full FIFO parks in FLUSH_PEND until a slot frees up.
        out_ready = 1'b0;
        feed(2'd1); feed(2'd1); feed(2'd1); feed(2'd1);
        feed(2'd2); feed(2'd2); feed(2'd2); feed(2'd2);
        feed(2'd3); feed(2'd1);
        chk("fp_count0", 32'(packed_count), 32'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fp_ready0", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            flush = 1'b0;
            chk("fp_hold_ready", 32'(in_ready), 32'd0);
            chk("fp_hold_count", 32'(packed_count), 32'd9);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fp_after_pop_ready", 32'(in_ready), 32'd0);
        chk("fp_after_pop_count", 32'(packed_count), 32'd9);
        tick();
        chk("fp_pushed_ready", 32'(in_ready), 32'd1);
        chk("fp_pushed_count", 32'(packed_count), 32'd10);
        chk("fp_head",         32'(out_data), 32'hAA);
        out_ready = 1'b1;
        tick();
        chk("fp_part_data",  32'(out_data), 32'h07);
        chk("fp_part_lanes", 32'(out_lanes), 32'd2);
        tick();
        chk("fp_drained", 32'(out_valid), 32'd0);

        // Reset mid-operation discards buffered and partial data.
        out_ready = 1'b0;
        feed(2'd1); feed(2'd2); feed(2'd3); feed(2'd0);
        feed(2'd3); feed(2'd3);
        chk("mr_count_pre", 32'(packed_count), 32'd11);
        reset_n = 1'b0;
        #1;
        chk("mr_ready_low", 32'(in_ready), 32'd0);
        tick();
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_count", 32'(packed_count), 32'd0);
        chk("mr_data",  32'(out_data), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        feed(2'd0); feed(2'd1); feed(2'd2); feed(2'd3);
        chk("mr_clean_data",  32'(out_data), 32'hE4);
        chk("mr_clean_lanes", 32'(out_lanes), 32'd4);
        chk("mr_clean_count", 32'(packed_count), 32'd1);
        tick();
        chk("mr_clean_gone", 32'(out_valid), 32'd0);

        // packed_count wraps 255 -> 0.
        acc = 0;
        for (int c = 0; c < 3000 && acc < 1016; c++) begin
            in_valid = 1'b1;
            in_data  = 2'd1;
            #1;
            rdy = in_ready;
            tick();
            if (rdy) acc++;
        end
        in_valid = 1'b0;
        chk("wrap_accepts", 32'(acc), 32'd1016);
        chk("wrap_255",     32'(packed_count), 32'd255);
        feed(2'd2); feed(2'd2); feed(2'd2); feed(2'd2);
        chk("wrap_0",    32'(packed_count), 32'd0);
        chk("wrap_data", 32'(out_data), 32'hAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
